// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default PC width and return-stack depth, plus the
// next-PC source encoding used by the program-counter unit.
package cpu_pkg;

    localparam int PC_W_DEF  = 10;
    localparam int DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        PCSRC_INC = 2'd0,
        PCSRC_JMP = 2'd1,
        PCSRC_RET = 2'd2
    } pc_src_e;

    function automatic pc_src_e pc_src_sel(input logic s_inc, input logic s_stack_mux);
        if (s_inc) begin
            return PCSRC_INC;
        end
        return s_stack_mux ? PCSRC_RET : PCSRC_JMP;
    endfunction

endpackage

// File: rtl/pc_stack_unit_if.sv
// Sequencing bus between the control unit (master) and the PC/stack unit (slave).
// There is no handshake: controls are sampled every rising edge, one instruction per cycle.
interface pc_stack_unit_if
    import cpu_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            s_inc;
    logic            s_stack_mux;
    logic            push;
    logic            pop;
    logic [PC_W-1:0] jump_addr;
    logic [PC_W-1:0] pc;
    logic [CW-1:0]   stack_count;
    logic            stack_full;
    logic            stack_empty;
    logic            stack_ovf;
    logic            stack_unf;

    modport master (
        output s_inc, s_stack_mux, push, pop, jump_addr,
        input  pc, stack_count, stack_full, stack_empty, stack_ovf, stack_unf
    );

    modport slave (
        input  s_inc, s_stack_mux, push, pop, jump_addr,
        output pc, stack_count, stack_full, stack_empty, stack_ovf, stack_unf
    );

endinterface

// File: rtl/ret_stack.sv
// Return-address LIFO with combinational top read from the registered array.
// Sticky overflow/underflow flags are built only when STACK_ERR_EN is defined.
module ret_stack
    import cpu_pkg::*;
#(
    parameter int W     = PC_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  push_data_i,
    output logic [W-1:0]  top_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          ovf_o,
    output logic          unf_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] top_idx;
    logic [AW-1:0] wr_idx;
    logic          mem_we;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign top_idx = count_q - CW'(1);
    assign top_o   = empty_o ? '0 : mem_q[top_idx[AW-1:0]];

    // Push+pop on a non-empty stack overwrites the top in place.
    always_comb begin
        count_d = count_q;
        mem_we  = 1'b0;
        wr_idx  = count_q[AW-1:0];
        if (push_i && pop_i && !empty_o) begin
            mem_we = 1'b1;
            wr_idx = top_idx[AW-1:0];
        end else if (push_i && !full_o) begin
            mem_we  = 1'b1;
            count_d = count_q + CW'(1);
        end else if (pop_i && !push_i && !empty_o) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem_q[wr_idx] <= push_data_i;
        end
    end

`ifdef STACK_ERR_EN
    logic ovf_evt, unf_evt;
    logic ovf_q, unf_q;

    assign ovf_evt = push_i && !pop_i && full_o;
    assign unf_evt = pop_i && !push_i && empty_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | ovf_evt;
            unf_q <= unf_q | unf_evt;
        end
    end

    assign ovf_o = ovf_q;
    assign unf_o = unf_q;
`else
    assign ovf_o = 1'b0;
    assign unf_o = 1'b0;
`endif

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter register, next-PC mux and return-address stack for the basic CPU.
// Define STACK_ERR_EN to build sticky overflow/underflow flags; otherwise they read 0.
module pc_stack_unit
    import cpu_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input logic             clk,
    input logic             reset,
    pc_stack_unit_if.slave  bus
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] stack_top;
    pc_src_e         pc_src;

    // Natural PC_W-bit wrap: the return address of the last word is 0.
    assign pc_plus1 = pc_q + PC_W'(1);
    assign pc_src   = pc_src_sel(bus.s_inc, bus.s_stack_mux);

    always_comb begin
        pc_d = pc_plus1;
        unique case (pc_src)
            PCSRC_INC: pc_d = pc_plus1;
            PCSRC_JMP: pc_d = bus.jump_addr;
            PCSRC_RET: pc_d = stack_top;
            default:   pc_d = pc_plus1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.pc = pc_q;

    ret_stack #(
        .W     (PC_W),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk         (clk),
        .reset       (reset),
        .push_i      (bus.push),
        .pop_i       (bus.pop),
        .push_data_i (pc_plus1),
        .top_o       (stack_top),
        .count_o     (bus.stack_count),
        .full_o      (bus.stack_full),
        .empty_o     (bus.stack_empty),
        .ovf_o       (bus.stack_ovf),
        .unf_o       (bus.stack_unf)
    );

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed plus random bench for pc_stack_unit against a queue-based reference model.
module tb_pc_stack_unit;

    localparam int PC_W  = 10;
    localparam int DEPTH = 8;
    localparam int MODW  = 1 << PC_W;

    logic clk;
    logic reset;

    pc_stack_unit_if #(.PC_W(PC_W), .DEPTH(DEPTH)) bus ();

    pc_stack_unit #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int m_pc;
    int m_stk[$];
    bit m_ovf;
    bit m_unf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit inc, input bit mux, input bit psh,
                              input bit pp, input int ja);
        int ret_addr;
        int top;
        int nxt;
        if (rst) begin
            m_pc = 0;
            m_stk.delete();
            m_ovf = 0;
            m_unf = 0;
            return;
        end
        ret_addr = (m_pc + 1) % MODW;
        top      = (m_stk.size() > 0) ? m_stk[$] : 0;
        nxt      = inc ? ret_addr : (mux ? top : ja);
        if (psh && pp && m_stk.size() > 0) begin
            void'(m_stk.pop_back());
            m_stk.push_back(ret_addr);
        end else if (psh) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(ret_addr);
            else if (!pp) m_ovf = 1;
        end else if (pp) begin
            if (m_stk.size() > 0) void'(m_stk.pop_back());
            else m_unf = 1;
        end
        m_pc = nxt;
    endtask

    task automatic check_all(input string tag);
        bit exp_ovf, exp_unf;
`ifdef STACK_ERR_EN
        exp_ovf = m_ovf;
        exp_unf = m_unf;
`else
        exp_ovf = 0;
        exp_unf = 0;
`endif
        check({tag, ".pc"},    32'(bus.pc),          32'(m_pc));
        check({tag, ".count"}, 32'(bus.stack_count), 32'(m_stk.size()));
        check({tag, ".full"},  32'(bus.stack_full),  32'(m_stk.size() == DEPTH));
        check({tag, ".empty"}, 32'(bus.stack_empty), 32'(m_stk.size() == 0));
        check({tag, ".ovf"},   32'(bus.stack_ovf),   32'(exp_ovf));
        check({tag, ".unf"},   32'(bus.stack_unf),   32'(exp_unf));
    endtask

    task automatic step(input string tag, input bit rst, input bit inc, input bit mux,
                        input bit psh, input bit pp, input int ja);
        @(negedge clk);
        reset           = rst;
        bus.s_inc       = inc;
        bus.s_stack_mux = mux;
        bus.push        = psh;
        bus.pop         = pp;
        bus.jump_addr   = PC_W'(ja);
        @(posedge clk);
        model_step(rst, inc, mux, psh, pp, ja);
        #1;
        check_all(tag);
    endtask

    task automatic do_inc(input string tag);  step(tag, 0, 1, 0, 0, 0, 0); endtask
    task automatic do_jmp(input string tag, input int a); step(tag, 0, 0, 0, 0, 0, a); endtask
    task automatic do_call(input string tag, input int a); step(tag, 0, 0, 0, 1, 0, a); endtask
    task automatic do_ret(input string tag);  step(tag, 0, 0, 1, 0, 1, 0); endtask
    task automatic do_rst(input string tag);  step(tag, 1, 0, 0, 0, 0, 0); endtask

    initial begin
        int r;
        reset           = 1'b1;
        bus.s_inc       = 1'b0;
        bus.s_stack_mux = 1'b0;
        bus.push        = 1'b0;
        bus.pop         = 1'b0;
        bus.jump_addr   = '0;
        m_pc = 0; m_ovf = 0; m_unf = 0;

        do_rst("reset0");
        do_rst("reset1");
        check("reset_pc_const", 32'(bus.pc), 32'd0);

        for (int i = 0; i < 5; i++) do_inc("inc");
        check("inc5_pc_const", 32'(bus.pc), 32'd5);

        do_jmp("jmp3", 3);
        do_call("call40", 'h40);
        check("call40_pc_const", 32'(bus.pc), 32'h40);
        do_inc("body");
        do_inc("body");
        do_ret("jr4");
        check("jr4_pc_const", 32'(bus.pc), 32'd4);

        // Nest to full depth, one overflowing push, then unwind past empty.
        for (int i = 0; i < DEPTH; i++) do_call("nest", 'h100 + i * 'h10);
        do_call("nest_ovf", 'h200);
        for (int i = 0; i < DEPTH; i++) do_ret("unwind");
        do_ret("jr_empty");
        check("jr_empty_pc_const", 32'(bus.pc), 32'd0);

        // Wrap of PC and of the pushed return address.
        do_jmp("to3ff", 'h3FF);
        do_inc("wrap_inc");
        do_jmp("to3ff_b", 'h3FF);
        do_call("call_at_3ff", 'h20);
        do_ret("ret_to_0");

        // Simultaneous push and pop with count=2 at pc=0x10, then reset mid-sequence.
        do_rst("rst_pp");
        do_call("pp_call1", 'h50);
        do_call("pp_call2", 'h60);
        do_jmp("pp_to10", 'h10);
        step("pp_both", 0, 1, 0, 1, 1, 0);
        do_ret("pp_ret");
        check("pp_ret_pc_const", 32'(bus.pc), 32'h11);
        do_call("pp_call3", 'h70);
        step("rst_mid", 1, 0, 0, 1, 0, 'h80);

        // Random instruction stream.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 35)      do_inc("rnd_inc");
            else if (r < 50) do_jmp("rnd_jmp", ($urandom_range(0, 7) == 0) ? 'h3FF : $urandom_range(0, MODW - 1));
            else if (r < 72) do_call("rnd_call", $urandom_range(0, MODW - 1));
            else if (r < 94) do_ret("rnd_ret");
            else if (r < 98) step("rnd_pp", 0, $urandom_range(0, 1), $urandom_range(0, 1), 1, 1, $urandom_range(0, MODW - 1));
            else             do_rst("rnd_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
